// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    RUN,
    ERR
  } state_e;

  localparam int LEN_BYTES = 4;

endpackage

// File: rtl/imem_boot_arbiter_byte_word_packer.sv
// Little-endian 8->32 assembler; word_valid_o flags the byte that completes a word,
// and word_o presents that completed word in the same cycle.
module byte_word_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_fire_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam logic [1:0] LAST_IDX = 2'(LEN_BYTES - 1);

  logic [1:0]  cnt_q;
  logic [23:0] asm_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (byte_fire_i) begin
      cnt_q <= cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    asm_q[7:0]   <= byte_i;
        2'd1:    asm_q[15:8]  <= byte_i;
        2'd2:    asm_q[23:16] <= byte_i;
        default: ;
      endcase
    end
  end

  assign word_o       = {byte_i, asm_q};
  assign word_valid_o = byte_fire_i && (cnt_q == LAST_IDX);

endmodule

// File: rtl/imem_boot_arbiter.sv
// Boot loader: streams a length-prefixed program into imem, then releases the
// imem read port and core_run to the fetch stage.
module imem_boot_arbiter
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       fetch_raddr,
  output logic [31:0]       imem_raddr,
  output logic              core_run,
  output logic              load_err,
  output logic [7:0]        load_sum,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [31:0]       len_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_waddr_q;
  logic [31:0]       imem_wdata_q;
  logic              core_run_q;
  logic              load_err_q;
  logic [7:0]        load_sum_q;
  logic [ADDR_W:0]   words_loaded_q;

  logic        byte_fire;
  logic [31:0] pk_word;
  logic        pk_valid;
  logic        len_over;
  logic        last_word;

  assign byte_ready = (state_q == LEN) || (state_q == LOAD);
  assign byte_fire  = byte_valid && byte_ready;
  assign imem_raddr = (state_q == RUN) ? fetch_raddr : 32'd0;
  assign len_over   = {1'b0, pk_word} > CAPACITY;
  assign last_word  = (32'(words_loaded_q) + 32'd1) == len_q;

  byte_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q == IDLE),
    .byte_fire_i  (byte_fire),
    .byte_i       (byte_data),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  // NOTE: next-state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LEN;
      LEN: begin
        if (pk_valid) begin
          if (pk_word == 32'd0) state_d = RUN;
          else if (len_over)    state_d = ERR;
          else                  state_d = LOAD;
        end
      end
      LOAD: if (pk_valid && last_word) state_d = RUN;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      imem_we_q      <= 1'b0;
      imem_waddr_q   <= '0;
      imem_wdata_q   <= '0;
      core_run_q     <= 1'b0;
      load_err_q     <= 1'b0;
      load_sum_q     <= '0;
      words_loaded_q <= '0;
    end else begin
      state_q    <= state_d;
      imem_we_q  <= 1'b0;
      // Lags the state by one cycle so the final write retires before release.
      core_run_q <= (state_q == RUN);

      if (state_q == IDLE && start) begin
        load_sum_q     <= '0;
        words_loaded_q <= '0;
      end

      if (state_q == LEN && pk_valid) begin
        len_q <= pk_word;
        if (len_over) load_err_q <= 1'b1;
      end

      if (state_q == LOAD && byte_fire) load_sum_q <= load_sum_q ^ byte_data;

      if (state_q == LOAD && pk_valid) begin
        imem_we_q      <= 1'b1;
        imem_waddr_q   <= words_loaded_q[ADDR_W-1:0];
        imem_wdata_q   <= pk_word;
        words_loaded_q <= words_loaded_q + 1'b1;
      end
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_waddr   = imem_waddr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_run     = core_run_q;
  assign load_err     = load_err_q;
  assign load_sum     = load_sum_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter with a small capacity (ADDR_W=4).
module tb_imem_boot_arbiter;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [31:0]       fetch_raddr;
  logic [31:0]       imem_raddr;
  logic              core_run;
  logic              load_err;
  logic [7:0]        load_sum;
  logic [ADDR_W:0]   words_loaded;

  int vectors = 0;
  int errs    = 0;

  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [31:0]       wr_data_log[$];

  imem_boot_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .fetch_raddr  (fetch_raddr),
    .imem_raddr   (imem_raddr),
    .core_run     (core_run),
    .load_err     (load_err),
    .load_sum     (load_sum),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_log.push_back(imem_waddr);
      wr_data_log.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  initial begin
    logic [31:0] prog [2];
    logic [31:0] three [3];
    logic [31:0] w;
    logic [7:0]  exp_sum;
    int          base;

    prog[0]  = 32'h0000_0013;
    prog[1]  = 32'h0010_0093;
    three[0] = 32'h1111_2222;
    three[1] = 32'h3333_4444;
    three[2] = 32'hCAFE_F00D;

    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    fetch_raddr = 32'h0000_0104;
    #12;
    check("rst_we",     32'(imem_we),      32'd0);
    check("rst_waddr",  32'(imem_waddr),   32'd0);
    check("rst_wdata",  imem_wdata,        32'd0);
    check("rst_run",    32'(core_run),     32'd0);
    check("rst_err",    32'(load_err),     32'd0);
    check("rst_sum",    32'(load_sum),     32'd0);
    check("rst_words",  32'(words_loaded), 32'd0);
    check("rst_ready",  32'(byte_ready),   32'd0);
    check("rst_raddr",  imem_raddr,        32'd0);
    rst = 1'b0;
    tick();

    // Bytes offered while idle are ignored.
    byte_valid = 1'b1; byte_data = 8'hAA;
    tick();
    check("idle_ready", 32'(byte_ready), 32'd0);
    check("idle_sum",   32'(load_sum),   32'd0);
    byte_valid = 1'b0;

    // Two-word load, continuous stream.
    pulse_start();
    check("len_ready", 32'(byte_ready), 32'd1);
    send_word(32'd2);
    check("load_raddr0", imem_raddr, 32'd0);
    send_word(prog[0]);
    check("w0_we",    32'(imem_we),      32'd1);
    check("w0_addr",  32'(imem_waddr),   32'd0);
    check("w0_data",  imem_wdata,        prog[0]);
    check("w0_words", 32'(words_loaded), 32'd1);
    send_word(prog[1]);
    check("w1_we",    32'(imem_we),      32'd1);
    check("w1_addr",  32'(imem_waddr),   32'd1);
    check("w1_data",  imem_wdata,        prog[1]);
    check("w1_run",   32'(core_run),     32'd0);
    check("w1_ready", 32'(byte_ready),   32'd0);
    tick();
    exp_sum = xor_bytes(prog[0]) ^ xor_bytes(prog[1]);
    check("p1_we",    32'(imem_we),      32'd0);
    check("p1_run",   32'(core_run),     32'd1);
    check("p1_sum",   32'(load_sum),     32'(exp_sum));
    check("p1_words", 32'(words_loaded), 32'd2);
    check("run_raddr", imem_raddr, 32'h0000_0104);
    pulse_start();
    tick();
    check("run_start_run",   32'(core_run),     32'd1);
    check("run_start_words", 32'(words_loaded), 32'd2);
    fetch_raddr = 32'h0000_2000;
    #1;
    check("run_raddr2", imem_raddr, 32'h0000_2000);

    // Zero-length program goes straight to RUN.
    do_reset();
    base = wr_data_log.size();
    pulse_start();
    send_word(32'd0);
    check("z_ready", 32'(byte_ready), 32'd0);
    check("z_run0",  32'(core_run),   32'd0);
    tick();
    check("z_run1",  32'(core_run),   32'd1);
    check("z_nowr",  32'(wr_data_log.size() - base), 32'd0);
    check("z_words", 32'(words_loaded), 32'd0);

    // Length one past capacity -> sticky error.
    do_reset();
    pulse_start();
    send_word(32'h0000_0011);
    check("e_err",   32'(load_err),   32'd1);
    check("e_ready", 32'(byte_ready), 32'd0);
    check("e_run",   32'(core_run),   32'd0);
    byte_valid = 1'b1; byte_data = 8'h55;
    pulse_start();
    tick(2);
    check("e2_err",   32'(load_err),     32'd1);
    check("e2_run",   32'(core_run),     32'd0);
    check("e2_ready", 32'(byte_ready),   32'd0);
    check("e2_sum",   32'(load_sum),     32'd0);
    check("e2_words", 32'(words_loaded), 32'd0);
    check("e2_raddr", imem_raddr,        32'd0);
    byte_valid = 1'b0;

    // Length exactly at capacity fills every address.
    do_reset();
    pulse_start();
    send_word(32'd16);
    check("cap_err", 32'(load_err), 32'd0);
    base = wr_data_log.size();
    exp_sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      w = 32'h0102_0304 * (i + 1);
      exp_sum ^= xor_bytes(w);
      send_word(w);
    end
    tick();
    check("cap_words", 32'(words_loaded), 32'd16);
    check("cap_nwr",   32'(wr_data_log.size() - base), 32'd16);
    check("cap_laddr", 32'(wr_addr_log[base+15]), 32'd15);
    check("cap_ldata", wr_data_log[base+15], 32'h0102_0304 * 16);
    check("cap_sum",   32'(load_sum), 32'(exp_sum));
    check("cap_run",   32'(core_run), 32'd1);

    // byte_valid toggling every cycle during LOAD.
    do_reset();
    pulse_start();
    send_word(32'd2);
    base = wr_data_log.size();
    for (int k = 0; k < 2; k++) begin
      w = prog[k];
      for (int i = 0; i < 4; i++) begin
        send(w[8*i +: 8]);
        tick();
      end
    end
    tick();
    exp_sum = xor_bytes(prog[0]) ^ xor_bytes(prog[1]);
    check("tg_nwr",   32'(wr_data_log.size() - base), 32'd2);
    check("tg_a0",    32'(wr_addr_log[base]),   32'd0);
    check("tg_d0",    wr_data_log[base],        prog[0]);
    check("tg_a1",    32'(wr_addr_log[base+1]), 32'd1);
    check("tg_d1",    wr_data_log[base+1],      prog[1]);
    check("tg_sum",   32'(load_sum), 32'(exp_sum));
    check("tg_run",   32'(core_run), 32'd1);

    // Reset in the middle of word 1 of a three-word load.
    do_reset();
    pulse_start();
    send_word(32'd3);
    send_word(32'hDEAD_BEEF);
    send(8'h11);
    send(8'h22);
    check("mr_words_pre", 32'(words_loaded), 32'd1);
    rst = 1'b1;
    #1;
    check("mr_words", 32'(words_loaded), 32'd0);
    check("mr_wdata", imem_wdata,        32'd0);
    check("mr_sum",   32'(load_sum),     32'd0);
    check("mr_ready", 32'(byte_ready),   32'd0);
    check("mr_raddr", imem_raddr,        32'd0);
    check("mr_run",   32'(core_run),     32'd0);
    #1;
    rst = 1'b0;
    tick();
    pulse_start();
    send_word(32'd3);
    base = wr_data_log.size();
    for (int k = 0; k < 3; k++) send_word(three[k]);
    tick();
    check("fr_nwr", 32'(wr_data_log.size() - base), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check("fr_addr", 32'(wr_addr_log[base+k]), 32'(k));
      check("fr_data", wr_data_log[base+k], three[k]);
    end
    check("fr_words", 32'(words_loaded), 32'd3);
    check("fr_run",   32'(core_run),     32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
